// File: rtl/aib_link_bringup_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aib_bringup_pkg
// Description : State encoding, default delays and debug-code helper for the
//               AIB link bring-up controller.
// Revision    : 1.0 - initial release
// ============================================================================
package aib_bringup_pkg;

    // ERR sits outside the 3-bit range; the exported debug code folds it onto 7
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CFG       = 4'd1,
        RST       = 4'd2,
        LOCK      = 4'd3,
        RXLOCK    = 4'd4,
        WAIT_XFER = 4'd5,
        UP        = 4'd6,
        DOWN      = 4'd7,
        ERR       = 4'd8
    } bringup_state_e;

    localparam int unsigned c_dflt_dly_w     = 16;
    localparam int unsigned c_dflt_t_cfg     = 20;
    localparam int unsigned c_dflt_t_rst     = 10;
    localparam int unsigned c_dflt_t_lock    = 12;
    localparam int unsigned c_dflt_t_rxlock  = 20;
    localparam int unsigned c_dflt_t_timeout = 4096;
    localparam int unsigned c_dflt_retry_w   = 4;

    function automatic logic [2:0] state_code(input bringup_state_e s);
        logic [3:0] v;
        v = s;
        return (s == ERR) ? 3'd7 : v[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aib_link_bringup_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aib_link_bringup_ctrl_if
// Description : Bring-up controls towards one AIB channel endpoint and the
//               transfer-enable status coming back from it.
// Revision    : 1.0 - initial release
// ============================================================================
interface aib_link_bringup_ctrl_if;
    logic config_done;
    logic ns_adapter_rstn;
    logic ns_mac_rdy;
    logic tx_dcc_dll_lock_req;
    logic rx_dcc_dll_lock_req;
    logic tx_transfer_en;
    logic rx_transfer_en;

    modport master (
        output config_done, ns_adapter_rstn, ns_mac_rdy,
               tx_dcc_dll_lock_req, rx_dcc_dll_lock_req,
        input  tx_transfer_en, rx_transfer_en
    );

    modport slave (
        input  config_done, ns_adapter_rstn, ns_mac_rdy,
               tx_dcc_dll_lock_req, rx_dcc_dll_lock_req,
        output tx_transfer_en, rx_transfer_en
    );
endinterface
`default_nettype wire

// File: rtl/aib_link_bringup_ctrl_sync.sv
`default_nettype none
// ============================================================================
// Module      : aib_bringup_sync
// Description : Two-flop synchronizer for a level signal, resets to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module aib_bringup_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/aib_link_bringup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aib_link_bringup_ctrl
// Description : MAC-side bring-up sequencer for one AIB channel endpoint with
//               teardown, far-side loss retrain and optional watchdog
//               (enabled by macro AIB_BRINGUP_WATCHDOG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module aib_link_bringup_ctrl
    import aib_bringup_pkg::*;
#(
    parameter int unsigned       DLY_W     = c_dflt_dly_w,
    parameter logic [DLY_W-1:0]  T_CFG     = DLY_W'(c_dflt_t_cfg),
    parameter logic [DLY_W-1:0]  T_RST     = DLY_W'(c_dflt_t_rst),
    parameter logic [DLY_W-1:0]  T_LOCK    = DLY_W'(c_dflt_t_lock),
    parameter logic [DLY_W-1:0]  T_RXLOCK  = DLY_W'(c_dflt_t_rxlock),
    parameter logic [DLY_W-1:0]  T_TIMEOUT = DLY_W'(c_dflt_t_timeout),
    parameter int unsigned       RETRY_W   = c_dflt_retry_w
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                start,
    input  wire logic                ms_nsl,
    aib_link_bringup_ctrl_if.master  ep,
    output logic                     link_up,
    output logic                     timeout_err,
    output logic [RETRY_W-1:0]       retrain_cnt,
    output logic [2:0]               state
);

    // DOWN holds one extra cycle so ns_mac_rdy drops ahead of the teardown gap
    localparam logic [DLY_W-1:0] c_t_down = T_RST + 1'b1;
    localparam logic [DLY_W-1:0] c_t_wdog = T_TIMEOUT - 1'b1;

    bringup_state_e      r_state, w_state_nxt;
    logic [DLY_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_config_done, w_config_done_nxt;
    logic                r_adapter_rstn, w_adapter_rstn_nxt;
    logic                r_mac_rdy, w_mac_rdy_nxt;
    logic                r_tx_lock, w_tx_lock_nxt;
    logic                r_rx_lock, w_rx_lock_nxt;
    logic                r_link_up, w_link_up_nxt;
    logic [RETRY_W-1:0]  r_retrain_cnt, w_retrain_nxt;
    logic [2:0]          r_state_dbg;
    logic                w_tx_sync, w_rx_sync, w_xfer_ok, w_expired, w_abort;
`ifdef AIB_BRINGUP_WATCHDOG_EN
    logic                r_timeout_err, w_timeout_nxt;
`endif

    aib_bringup_sync u_sync_tx (.clk(clk), .rst_n(rst_n), .i_d(ep.tx_transfer_en), .o_q(w_tx_sync));
    aib_bringup_sync u_sync_rx (.clk(clk), .rst_n(rst_n), .i_d(ep.rx_transfer_en), .o_q(w_rx_sync));

    assign w_xfer_ok = w_tx_sync & w_rx_sync;
    assign w_expired = (r_cnt == '0);
    assign w_abort   = !start && !(r_state inside {IDLE, DOWN, ERR});

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = w_expired ? r_cnt : r_cnt - 1'b1;
        w_config_done_nxt  = r_config_done;
        w_adapter_rstn_nxt = r_adapter_rstn;
        w_mac_rdy_nxt      = r_mac_rdy;
        w_tx_lock_nxt      = r_tx_lock;
        w_rx_lock_nxt      = r_rx_lock;
        w_link_up_nxt      = r_link_up;
        w_retrain_nxt      = r_retrain_cnt;
`ifdef AIB_BRINGUP_WATCHDOG_EN
        w_timeout_nxt      = r_timeout_err;
`endif
        if (w_abort) begin
            // a dropped start outranks everything, including a coincident xfer loss
            w_state_nxt   = DOWN;
            w_cnt_nxt     = c_t_down;
            w_link_up_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = CFG;
                        w_cnt_nxt   = T_CFG;
`ifdef AIB_BRINGUP_WATCHDOG_EN
                        w_timeout_nxt = 1'b0;
`endif
                    end
                end
                CFG: begin
                    if (w_expired) begin
                        w_config_done_nxt = 1'b1;
                        w_state_nxt       = RST;
                        w_cnt_nxt         = T_RST;
                    end
                end
                RST: begin
                    if (w_expired) begin
                        w_adapter_rstn_nxt = 1'b1;
                        w_mac_rdy_nxt      = 1'b1;
                        w_state_nxt        = LOCK;
                        w_cnt_nxt          = T_LOCK;
                    end
                end
                LOCK: begin
                    if (w_expired) begin
                        w_tx_lock_nxt = 1'b1;
                        if (ms_nsl) begin
                            w_rx_lock_nxt = 1'b1;
                            w_state_nxt   = WAIT_XFER;
                            w_cnt_nxt     = c_t_wdog;
                        end else begin
                            w_state_nxt   = RXLOCK;
                            w_cnt_nxt     = T_RXLOCK;
                        end
                    end
                end
                RXLOCK: begin
                    if (w_expired) begin
                        w_rx_lock_nxt = 1'b1;
                        w_state_nxt   = WAIT_XFER;
                        w_cnt_nxt     = c_t_wdog;
                    end
                end
                WAIT_XFER: begin
                    if (w_xfer_ok) begin
                        w_link_up_nxt = 1'b1;
                        w_state_nxt   = UP;
                    end
`ifdef AIB_BRINGUP_WATCHDOG_EN
                    else if (w_expired) begin
                        w_state_nxt        = ERR;
                        w_timeout_nxt      = 1'b1;
                        w_mac_rdy_nxt      = 1'b0;
                        w_adapter_rstn_nxt = 1'b0;
                        w_tx_lock_nxt      = 1'b0;
                        w_rx_lock_nxt      = 1'b0;
                        w_link_up_nxt      = 1'b0;
                    end
`endif
                end
                UP: begin
                    if (!w_xfer_ok) begin
                        w_link_up_nxt = 1'b0;
                        w_state_nxt   = DOWN;
                        w_cnt_nxt     = c_t_down;
                        if (r_retrain_cnt != '1) begin
                            w_retrain_nxt = r_retrain_cnt + 1'b1;
                        end
                    end
                end
                DOWN: begin
                    w_mac_rdy_nxt = 1'b0;
                    if (w_expired) begin
                        w_adapter_rstn_nxt = 1'b0;
                        w_tx_lock_nxt      = 1'b0;
                        w_rx_lock_nxt      = 1'b0;
                        if (start) begin
                            w_state_nxt = RST;
                            w_cnt_nxt   = T_RST;
                        end else begin
                            w_config_done_nxt = 1'b0;
                            w_state_nxt       = IDLE;
                        end
                    end
                end
                ERR: begin
                    if (!start) begin
                        w_config_done_nxt = 1'b0;
                        w_state_nxt       = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_config_done  <= 1'b0;
            r_adapter_rstn <= 1'b0;
            r_mac_rdy      <= 1'b0;
            r_tx_lock      <= 1'b0;
            r_rx_lock      <= 1'b0;
            r_link_up      <= 1'b0;
            r_retrain_cnt  <= '0;
            r_state_dbg    <= 3'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_config_done  <= w_config_done_nxt;
            r_adapter_rstn <= w_adapter_rstn_nxt;
            r_mac_rdy      <= w_mac_rdy_nxt;
            r_tx_lock      <= w_tx_lock_nxt;
            r_rx_lock      <= w_rx_lock_nxt;
            r_link_up      <= w_link_up_nxt;
            r_retrain_cnt  <= w_retrain_nxt;
            r_state_dbg    <= state_code(w_state_nxt);
        end
    end

`ifdef AIB_BRINGUP_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout_nxt;
        end
    end
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    assign ep.config_done         = r_config_done;
    assign ep.ns_adapter_rstn     = r_adapter_rstn;
    assign ep.ns_mac_rdy          = r_mac_rdy;
    assign ep.tx_dcc_dll_lock_req = r_tx_lock;
    assign ep.rx_dcc_dll_lock_req = r_rx_lock;
    assign link_up                = r_link_up;
    assign retrain_cnt            = r_retrain_cnt;
    assign state                  = r_state_dbg;

endmodule
`default_nettype wire
